// File: rtl/tnew_pkg.sv
// Shared decode constants, Tnew/Tuse classes, scoreboard entry layout and forward-select encoding.
// Pure definitions: no latency and no flow control.
package tnew_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam int TNEW_LINK  = 0;
    localparam int TNEW_ALU   = 1;
    localparam int TNEW_LOAD  = 2;
    localparam int TUSE_BR    = 0;
    localparam int TUSE_ALU   = 1;
    localparam int TUSE_STORE = 2;
    localparam int REG_RA     = 31;

    // Entry fields are sized for the widest supported parameters; narrower
    // instances zero-extend into them.
    localparam int REGW_MAX = 8;
    localparam int TW_MAX   = 4;

    typedef struct packed {
        logic                vld;
        logic [REGW_MAX-1:0] dst;
        logic [TW_MAX-1:0]   tnew;
    } entry_t;

    localparam int         FWD_W  = 3;
    localparam logic [2:0] FWD_RF = 3'd0;

    function automatic logic [FWD_W-1:0] fwd_sel(input int stage);
        return FWD_W'(stage + 1);
    endfunction

    function automatic int tuse_none(input int tw);
        return (1 << tw) - 1;
    endfunction

endpackage

// File: rtl/tnew_decode.sv
// Combinational op/funct decode to write target, Tnew and per-operand Tuse.
// Zero latency; no flow control.
module tnew_decode
    import tnew_pkg::*;
#(
    parameter int REGW = 5,
    parameter int TW   = 2
) (
    input  logic [5:0]      op,
    input  logic [5:0]      funct,
    input  logic [REGW-1:0] rt,
    input  logic [REGW-1:0] rd,
    output logic [REGW-1:0] dst,
    output logic [TW-1:0]   tnew,
    output logic [TW-1:0]   tuse_rs,
    output logic [TW-1:0]   tuse_rt
);

    localparam logic [TW-1:0] NONE = TW'(tuse_none(TW));

    always_comb begin
        dst     = '0;
        tnew    = '0;
        tuse_rs = NONE;
        tuse_rt = NONE;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND: begin
                        dst     = rd;
                        tnew    = TW'(TNEW_ALU);
                        tuse_rs = TW'(TUSE_ALU);
                        tuse_rt = TW'(TUSE_ALU);
                    end
                    FN_JR:   tuse_rs = TW'(TUSE_BR);
                    default: ;
                endcase
            end
            OP_ORI, OP_ADDI: begin
                dst     = rt;
                tnew    = TW'(TNEW_ALU);
                tuse_rs = TW'(TUSE_ALU);
            end
            OP_LUI: begin
                dst  = rt;
                tnew = TW'(TNEW_ALU);
            end
            OP_LW: begin
                dst     = rt;
                tnew    = TW'(TNEW_LOAD);
                tuse_rs = TW'(TUSE_ALU);
            end
            OP_SW: begin
                tuse_rs = TW'(TUSE_ALU);
                tuse_rt = TW'(TUSE_STORE);
            end
            OP_BEQ: begin
                tuse_rs = TW'(TUSE_BR);
                tuse_rt = TW'(TUSE_BR);
            end
            OP_JAL: begin
                dst  = REGW'(REG_RA);
                tnew = TW'(TNEW_LINK);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/tnew_scoreboard.sv
// Tnew/Tuse hazard scoreboard: D-stage stall plus D- and E-stage forward selects.
// Outputs are combinational from current state; stall holds D and injects an E bubble, stages below E always advance.
module tnew_scoreboard
    import tnew_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int REGW   = 5,
    parameter int TW     = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            d_valid,
    input  logic [5:0]      d_op,
    input  logic [5:0]      d_funct,
    input  logic [REGW-1:0] d_rs,
    input  logic [REGW-1:0] d_rt,
    input  logic [REGW-1:0] d_rd,
    input  logic            flush,
    output logic            stall,
    output logic [2:0]      fwd_d_rs,
    output logic [2:0]      fwd_d_rt,
    output logic [2:0]      fwd_e_rs,
    output logic [2:0]      fwd_e_rt
);

    localparam logic [TW-1:0] NONE = TW'(tuse_none(TW));

    typedef struct packed {
        logic              hit;
        logic [FWD_W-1:0]  sel;
        logic [TW_MAX-1:0] tnew;
    } look_t;

    logic [REGW-1:0] dec_dst;
    logic [TW-1:0]   dec_tnew;
    logic [TW-1:0]   dec_tuse_rs;
    logic [TW-1:0]   dec_tuse_rt;

    entry_t [NSTAGE-1:0] sb_q, sb_d;
    logic [REGW-1:0]     e_rs_q, e_rs_d, e_rt_q, e_rt_d;

    look_t look_d_rs, look_d_rt, look_e_rs, look_e_rt;
    logic  stall_rs, stall_rt, bubble;

    tnew_decode #(
        .REGW (REGW),
        .TW   (TW)
    ) u_decode (
        .op      (d_op),
        .funct   (d_funct),
        .rt      (d_rt),
        .rd      (d_rd),
        .dst     (dec_dst),
        .tnew    (dec_tnew),
        .tuse_rs (dec_tuse_rs),
        .tuse_rt (dec_tuse_rt)
    );

    // Scan oldest to youngest so the youngest match overwrites any older one.
    function automatic look_t lookup(input entry_t [NSTAGE-1:0] sb,
                                     input logic [REGW-1:0] r, input int lo);
        look_t res;
        res = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (i >= lo && sb[i].vld && sb[i].dst != '0 && sb[i].dst == REGW_MAX'(r)) begin
                res.hit  = 1'b1;
                res.sel  = fwd_sel(i);
                res.tnew = sb[i].tnew;
            end
        end
        return res;
    endfunction

    always_comb begin
        look_d_rs = lookup(sb_q, d_rs, 0);
        look_d_rt = lookup(sb_q, d_rt, 0);
        look_e_rs = lookup(sb_q, e_rs_q, 1);
        look_e_rt = lookup(sb_q, e_rt_q, 1);

        stall_rs = d_valid && look_d_rs.hit && (dec_tuse_rs != NONE) &&
                   (look_d_rs.tnew > TW_MAX'(dec_tuse_rs));
        stall_rt = d_valid && look_d_rt.hit && (dec_tuse_rt != NONE) &&
                   (look_d_rt.tnew > TW_MAX'(dec_tuse_rt));
        stall    = stall_rs | stall_rt;

        fwd_d_rs = (d_valid && !stall && look_d_rs.hit && look_d_rs.tnew == '0) ? look_d_rs.sel : FWD_RF;
        fwd_d_rt = (d_valid && !stall && look_d_rt.hit && look_d_rt.tnew == '0) ? look_d_rt.sel : FWD_RF;
        fwd_e_rs = (look_e_rs.hit && look_e_rs.tnew == '0) ? look_e_rs.sel : FWD_RF;
        fwd_e_rt = (look_e_rt.hit && look_e_rt.tnew == '0) ? look_e_rt.sel : FWD_RF;
    end

    always_comb begin
        bubble = stall | flush | !d_valid;

        sb_d[0] = '0;
        if (!bubble) begin
            sb_d[0].vld  = 1'b1;
            sb_d[0].dst  = REGW_MAX'(dec_dst);
            sb_d[0].tnew = TW_MAX'(dec_tnew);
        end
        for (int i = 1; i < NSTAGE; i++) begin
            sb_d[i] = sb_q[i-1];
            if (sb_q[i-1].tnew != '0) begin
                sb_d[i].tnew = sb_q[i-1].tnew - TW_MAX'(1);
            end
        end

        e_rs_d = bubble ? '0 : d_rs;
        e_rt_d = bubble ? '0 : d_rt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q   <= '0;
            e_rs_q <= '0;
            e_rt_q <= '0;
        end else begin
            sb_q   <= sb_d;
            e_rs_q <= e_rs_d;
            e_rt_q <= e_rt_d;
        end
    end

endmodule

// File: tb/tb_tnew_scoreboard.sv
// Directed hazard scenarios followed by randomized instruction streams, checked against a stage/age model.
module tb_tnew_scoreboard;

    localparam int NSTAGE = 3;
    localparam int REGW   = 5;
    localparam int TW     = 2;

    localparam logic [5:0] OP_R = 6'b000000, OP_ORI = 6'b001101, OP_ADDI = 6'b001000,
                           OP_LUI = 6'b001111, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_JAL = 6'b000011;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100,
                           FN_JR = 6'b001000;

    logic            clk = 1'b0;
    logic            reset, d_valid, flush;
    logic [5:0]      d_op, d_funct;
    logic [REGW-1:0] d_rs, d_rt, d_rd;
    logic            stall;
    logic [2:0]      fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit vld;
        int dst;
        int tnew0;
    } prod_t;

    prod_t pipe [NSTAGE];
    int    e_rs_m, e_rt_m;
    int    exp_stall, exp_fdrs, exp_fdrt, exp_fers, exp_fert;

    tnew_scoreboard #(.NSTAGE(NSTAGE), .REGW(REGW), .TW(TW)) dut (
        .clk      (clk),
        .reset    (reset),
        .d_valid  (d_valid),
        .d_op     (d_op),
        .d_funct  (d_funct),
        .d_rs     (d_rs),
        .d_rt     (d_rt),
        .d_rd     (d_rd),
        .flush    (flush),
        .stall    (stall),
        .fwd_d_rs (fwd_d_rs),
        .fwd_d_rt (fwd_d_rt),
        .fwd_e_rs (fwd_e_rs),
        .fwd_e_rt (fwd_e_rt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Instruction table: dst, Tnew from E, Tuse per operand (-1 = unused).
    function automatic void decode(input logic [5:0] op, input logic [5:0] funct,
                                   input int rt, input int rd,
                                   output int dst, output int tnew, output int urs, output int urt);
        dst = 0; tnew = 0; urs = -1; urt = -1;
        case (op)
            OP_R: begin
                if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND) begin
                    dst = rd; tnew = 1; urs = 1; urt = 1;
                end else if (funct == FN_JR) begin
                    urs = 0;
                end
            end
            OP_ORI, OP_ADDI: begin dst = rt; tnew = 1; urs = 1; end
            OP_LUI:          begin dst = rt; tnew = 1; end
            OP_LW:           begin dst = rt; tnew = 2; urs = 1; end
            OP_SW:           begin urs = 1; urt = 2; end
            OP_BEQ:          begin urs = 0; urt = 0; end
            OP_JAL:          begin dst = 31; tnew = 0; end
            default: ;
        endcase
    endfunction

    // Youngest producer of r at stage >= lo: returns stage+1 (0 if none), rem = cycles until ready.
    function automatic int find(input int r, input int lo, output int rem);
        rem = 0;
        for (int i = lo; i < NSTAGE; i++) begin
            if (pipe[i].vld && r != 0 && pipe[i].dst == r) begin
                rem = (pipe[i].tnew0 > i) ? pipe[i].tnew0 - i : 0;
                return i + 1;
            end
        end
        return 0;
    endfunction

    function automatic void model_eval();
        int dst, tn, urs, urt, srs, srt, rrs, rrt, ers, ert, r0, r1;
        decode(d_op, d_funct, int'(d_rt), int'(d_rd), dst, tn, urs, urt);
        srs = find(int'(d_rs), 0, rrs);
        srt = find(int'(d_rt), 0, rrt);
        exp_stall = (d_valid && ((srs != 0 && urs >= 0 && rrs > urs) ||
                                 (srt != 0 && urt >= 0 && rrt > urt))) ? 1 : 0;
        exp_fdrs  = (d_valid && exp_stall == 0 && srs != 0 && rrs == 0) ? srs : 0;
        exp_fdrt  = (d_valid && exp_stall == 0 && srt != 0 && rrt == 0) ? srt : 0;
        ers = find(e_rs_m, 1, r0);
        ert = find(e_rt_m, 1, r1);
        exp_fers  = (ers != 0 && r0 == 0) ? ers : 0;
        exp_fert  = (ert != 0 && r1 == 0) ? ert : 0;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NSTAGE; i++) pipe[i] = '{0, 0, 0};
        e_rs_m = 0;
        e_rt_m = 0;
    endfunction

    function automatic void model_adv();
        int dst, tn, urs, urt;
        model_eval();
        if (reset) begin
            model_clear();
        end else begin
            decode(d_op, d_funct, int'(d_rt), int'(d_rd), dst, tn, urs, urt);
            for (int i = NSTAGE - 1; i > 0; i--) pipe[i] = pipe[i-1];
            if (exp_stall != 0 || flush || !d_valid) begin
                pipe[0] = '{0, 0, 0};
                e_rs_m  = 0;
                e_rt_m  = 0;
            end else begin
                pipe[0] = '{1, dst, tn};
                e_rs_m  = int'(d_rs);
                e_rt_m  = int'(d_rt);
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input int exp);
        checks++;
        assert (obs === 4'(exp)) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic look();
        @(negedge clk);
        model_eval();
        chk("stall",    {3'b0, stall},    exp_stall);
        chk("fwd_d_rs", {1'b0, fwd_d_rs}, exp_fdrs);
        chk("fwd_d_rt", {1'b0, fwd_d_rt}, exp_fdrt);
        chk("fwd_e_rs", {1'b0, fwd_e_rs}, exp_fers);
        chk("fwd_e_rt", {1'b0, fwd_e_rt}, exp_fert);
    endtask

    task automatic step();
        @(posedge clk);
        model_adv();
        #1;
    endtask

    task automatic set(input logic [5:0] op, input logic [5:0] fn,
                       input int rs, input int rt, input int rd);
        d_valid = 1'b1;
        d_op    = op;
        d_funct = fn;
        d_rs    = REGW'(rs);
        d_rt    = REGW'(rt);
        d_rd    = REGW'(rd);
    endtask

    task automatic drain();
        set(OP_R, 6'd0, 0, 0, 0);
        repeat (NSTAGE) begin look(); step(); end
    endtask

    task automatic pick();
        logic [5:0] op, fn;
        int rs, rt, rd;
        case ($urandom_range(0, 10))
            0, 1:    op = OP_R;
            2:       op = OP_ORI;
            3:       op = OP_ADDI;
            4:       op = OP_LUI;
            5:       op = OP_LW;
            6:       op = OP_SW;
            7:       op = OP_BEQ;
            8:       op = OP_J;
            9:       op = OP_JAL;
            default: op = 6'b111111;
        endcase
        case ($urandom_range(0, 4))
            0:       fn = FN_ADD;
            1:       fn = FN_SUB;
            2:       fn = FN_AND;
            3:       fn = FN_JR;
            default: fn = 6'b101010;
        endcase
        rs = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 7));
        rt = int'($urandom_range(0, 7));
        rd = int'($urandom_range(0, 7));
        set(op, fn, rs, rt, rd);
    endtask

    task automatic test1();
        set(OP_LW, 6'd0, 0, 8, 0);
        look(); step();
        set(OP_R, FN_ADD, 8, 8, 9);
        look(); chk("t1_c1_stall", {3'b0, stall}, 1);
        step();
        look(); chk("t1_c2_stall", {3'b0, stall}, 0);
        chk("t1_c2_fdrs", {1'b0, fwd_d_rs}, 0);
        chk("t1_c2_fdrt", {1'b0, fwd_d_rt}, 0);
        step();
        set(OP_R, 6'd0, 0, 0, 0);
        look(); chk("t1_c3_fers", {1'b0, fwd_e_rs}, 3);
        chk("t1_c3_fert", {1'b0, fwd_e_rt}, 3);
        step();
    endtask

    initial begin
        model_clear();
        reset = 1'b1; flush = 1'b0;
        set(OP_R, 6'd0, 0, 0, 0);
        d_valid = 1'b0;
        step(); step();
        reset = 1'b0;
        look();
        chk("rst_stall", {3'b0, stall}, 0);
        chk("rst_fdrs", {1'b0, fwd_d_rs}, 0);
        chk("rst_fers", {1'b0, fwd_e_rs}, 0);
        step();

        test1();

        drain();
        set(OP_ADDI, 6'd0, 0, 5, 0);
        look(); step();
        set(OP_BEQ, 6'd0, 5, 0, 0);
        look(); chk("t2_c1_stall", {3'b0, stall}, 1);
        step();
        look(); chk("t2_c2_stall", {3'b0, stall}, 0);
        chk("t2_c2_fdrs", {1'b0, fwd_d_rs}, 2);
        step();

        drain();
        set(OP_JAL, 6'd0, 0, 0, 0);
        look(); step();
        set(OP_R, FN_JR, 31, 0, 0);
        look(); chk("t3_stall", {3'b0, stall}, 0);
        chk("t3_fdrs", {1'b0, fwd_d_rs}, 1);
        step();

        drain();
        set(OP_LW, 6'd0, 0, 3, 0);
        look(); step();
        set(OP_ORI, 6'd0, 0, 3, 0);
        look(); step();
        set(OP_SW, 6'd0, 0, 3, 0);
        look(); chk("t4_stall", {3'b0, stall}, 0);
        chk("t4_fdrt", {1'b0, fwd_d_rt}, 0);
        step();
        set(OP_R, 6'd0, 0, 0, 0);
        look(); chk("t4_fert", {1'b0, fwd_e_rt}, 2);
        step();

        drain();
        set(OP_LW, 6'd0, 0, 0, 0);
        look(); step();
        set(OP_R, FN_ADD, 0, 0, 1);
        look(); chk("t5_r0_stall", {3'b0, stall}, 0);
        chk("t5_r0_fdrs", {1'b0, fwd_d_rs}, 0);
        step();
        set(OP_SW, 6'd0, 7, 7, 7);
        look(); step();
        set(OP_BEQ, 6'd0, 7, 7, 7);
        look(); chk("t5_sw_stall", {3'b0, stall}, 0);
        step();
        set(OP_J, 6'd0, 7, 7, 7);
        look(); chk("t5_beq_stall", {3'b0, stall}, 0);
        step();
        set(OP_R, FN_ADD, 7, 7, 2);
        look(); chk("t5_j_stall", {3'b0, stall}, 0);
        chk("t5_j_fdrs", {1'b0, fwd_d_rs}, 0);
        chk("t5_j_fdrt", {1'b0, fwd_d_rt}, 0);
        step();

        // Squashed producer must leave no trace.
        drain();
        set(OP_ADDI, 6'd0, 0, 5, 0);
        flush = 1'b1;
        look(); step();
        flush = 1'b0;
        set(OP_BEQ, 6'd0, 5, 0, 0);
        look(); chk("fl_stall", {3'b0, stall}, 0);
        chk("fl_fdrs", {1'b0, fwd_d_rs}, 0);
        step();

        // Stall and flush together insert a single bubble.
        drain();
        set(OP_LW, 6'd0, 0, 8, 0);
        look(); step();
        set(OP_R, FN_ADD, 8, 8, 9);
        flush = 1'b1;
        look(); chk("sf_stall", {3'b0, stall}, 1);
        step();
        flush = 1'b0;
        look(); chk("sf_stall2", {3'b0, stall}, 0);
        step();
        set(OP_R, 6'd0, 0, 0, 0);
        look(); chk("sf_fers", {1'b0, fwd_e_rs}, 3);
        step();

        // Producer in the last stage, then gone.
        drain();
        set(OP_ADDI, 6'd0, 0, 5, 0);
        look(); step();
        set(OP_R, 6'd0, 0, 0, 0);
        look(); step();
        look(); step();
        set(OP_BEQ, 6'd0, 5, 0, 0);
        look(); chk("last_fdrs", {1'b0, fwd_d_rs}, 3);
        step();
        look(); chk("gone_fdrs", {1'b0, fwd_d_rs}, 0);
        step();

        // Reset in the middle of a load-use stall.
        drain();
        set(OP_LW, 6'd0, 0, 8, 0);
        look(); step();
        set(OP_R, FN_ADD, 8, 8, 9);
        reset = 1'b1;
        look(); chk("t6_pre_stall", {3'b0, stall}, 1);
        step();
        reset = 1'b0;
        look(); chk("t6_stall", {3'b0, stall}, 0);
        chk("t6_fdrs", {1'b0, fwd_d_rs}, 0);
        chk("t6_fdrt", {1'b0, fwd_d_rt}, 0);
        chk("t6_fers", {1'b0, fwd_e_rs}, 0);
        chk("t6_fert", {1'b0, fwd_e_rt}, 0);
        step();
        drain();
        test1();

        for (int n = 0; n < 800; n++) begin
            if (exp_stall == 0 || reset) pick();
            d_valid = ($urandom_range(0, 9) != 0);
            flush   = ($urandom_range(0, 9) == 0);
            reset   = ($urandom_range(0, 49) == 0);
            look(); step();
        end
        reset = 1'b0; flush = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
